// File: rtl/paddle_move_sched.sv
// Paddle move scheduler: pending-move counters, tick-driven request latch and round-robin
// issue on one valid/ready update port (tick to first update in 2 edges; the offer is held while upd_ready is low). Optional macro: PADDLE_ACCEL_EN.
module paddle_move_sched #(
  parameter int POS_W    = 6,
  parameter int POS_MAX  = 47,
  parameter int POS_INIT = 20,
  parameter int PEND_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             p0_left,
  input  logic             p0_right,
  input  logic             p1_left,
  input  logic             p1_right,
  input  logic             upd_ready,
  output logic             upd_valid,
  output logic             upd_player,
  output logic [POS_W-1:0] upd_pos,
  output logic [POS_W-1:0] pos0,
  output logic [POS_W-1:0] pos1,
  output logic             busy
);
  localparam int PMAX = (1 << (PEND_W - 1)) - 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                   state_q, state_d;
  logic [POS_W-1:0]         pos_q  [2];
  logic [POS_W-1:0]         pos_d  [2];
  logic signed [PEND_W-1:0] pend_q [2];
  logic signed [PEND_W-1:0] pend_d [2];
  logic [1:0]               step_q [2];
  logic [1:0]               step_d [2];
  logic [1:0]               req_q, req_d;
  logic [1:0]               dir_q, dir_d;
  logic                     rr_q, rr_d;
  logic                     vld_q, vld_d;
  logic                     pl_q, pl_d;
  logic [POS_W-1:0]         upos_q, upos_d;
  logic                     pick;
  logic [1:0]               lft, rgt;

  assign lft = {p1_left, p0_left};
  assign rgt = {p1_right, p0_right};

  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p,
                                                input logic right,
                                                input logic [1:0] s);
    return right ? p + POS_W'(s) : p - POS_W'(s);
  endfunction

  // Per-player pending counter, request latch and position write-back.
  always_comb begin
    int   p;
    int   room;
    int   stp;
    int   take;
    logic hs;
    logic latch;
    p     = 0;
    room  = 0;
    stp   = 0;
    take  = 0;
    hs    = 1'b0;
    latch = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pos_d[i]  = pos_q[i];
      step_d[i] = step_q[i];
      req_d[i]  = req_q[i];
      dir_d[i]  = dir_q[i];
      p         = int'($signed(pend_q[i]));
      hs        = vld_q && upd_ready && (pl_q == 1'(i));
      latch     = tick && !req_q[i] && (pend_q[i] != '0);
      room      = pend_q[i][PEND_W-1] ? int'(pos_q[i]) : POS_MAX - int'(pos_q[i]);
`ifdef PADDLE_ACCEL_EN
      stp = (p >= 2 || p <= -2) ? 2 : 1;
`else
      stp = 1;
`endif
      if (stp > room) stp = room;

      if (latch) begin
        // Nothing left to move toward: the request is discarded with its backlog.
        if (stp == 0) begin
          p = 0;
        end else begin
          req_d[i]  = 1'b1;
          dir_d[i]  = ~pend_q[i][PEND_W-1];
          step_d[i] = 2'(stp);
        end
      end

      if (hs) begin
        pos_d[i] = upos_q;
        req_d[i] = 1'b0;
        take     = int'(step_q[i]);
        if (p > 0)      p = p - ((take < p) ? take : p);
        else if (p < 0) p = p + ((take < -p) ? take : -p);
      end

      p = p + int'(rgt[i]) - int'(lft[i]);
      if (p > PMAX)       p = PMAX;
      else if (p < -PMAX) p = -PMAX;
      pend_d[i] = PEND_W'(p);
    end
  end

  // Issue FSM: the update port is granted round-robin, back-to-back when both wait.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    pl_d    = pl_q;
    upos_d  = upos_q;
    rr_d    = rr_q;
    pick    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_q) begin
          pick    = (&req_q) ? rr_q : req_q[1];
          vld_d   = 1'b1;
          pl_d    = pick;
          upos_d  = next_pos(pos_q[pick], dir_q[pick], step_q[pick]);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (upd_ready) begin
          pick = ~pl_q;
          rr_d = ~pl_q;
          if (req_q[pick]) begin
            pl_d   = pick;
            upos_d = next_pos(pos_q[pick], dir_q[pick], step_q[pick]);
          end else begin
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pos_q[0]  <= POS_W'(POS_INIT);
      pos_q[1]  <= POS_W'(POS_INIT);
      pend_q[0] <= '0;
      pend_q[1] <= '0;
      step_q[0] <= 2'd0;
      step_q[1] <= 2'd0;
      req_q     <= 2'b00;
      dir_q     <= 2'b00;
      rr_q      <= 1'b0;
      vld_q     <= 1'b0;
      pl_q      <= 1'b0;
      upos_q    <= '0;
    end else begin
      state_q   <= state_d;
      pos_q[0]  <= pos_d[0];
      pos_q[1]  <= pos_d[1];
      pend_q[0] <= pend_d[0];
      pend_q[1] <= pend_d[1];
      step_q[0] <= step_d[0];
      step_q[1] <= step_d[1];
      req_q     <= req_d;
      dir_q     <= dir_d;
      rr_q      <= rr_d;
      vld_q     <= vld_d;
      pl_q      <= pl_d;
      upos_q    <= upos_d;
    end
  end

  assign upd_valid  = vld_q;
  assign upd_player = pl_q;
  assign upd_pos    = upos_q;
  assign pos0       = pos_q[0];
  assign pos1       = pos_q[1];
  assign busy       = (|req_q) | vld_q;

endmodule

// File: tb/tb_paddle_move_sched.sv
// Bench for paddle_move_sched: cycle vectors with expected outputs, plus a handshake scoreboard.
module tb_paddle_move_sched;
  logic       clk = 1'b0;
  logic       rst_n, tick, p0_left, p0_right, p1_left, p1_right, upd_ready;
  logic       upd_valid, upd_player, busy;
  logic [5:0] upd_pos, pos0, pos1;

  paddle_move_sched dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .p0_left(p0_left), .p0_right(p0_right), .p1_left(p1_left), .p1_right(p1_right),
    .upd_ready(upd_ready), .upd_valid(upd_valid), .upd_player(upd_player),
    .upd_pos(upd_pos), .pos0(pos0), .pos1(pos1), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic l0, r0, l1, r1, t, rdy;
    int   e0, e1;
    logic vld, pl;
    int   upos;
    logic bsy;
  } vec_t;

  typedef struct {
    logic pl;
    int   pos;
  } upd_t;

  vec_t tbl[$];
  upd_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   prev0 = 20;
  int   prev1 = 20;

  function automatic vec_t mk(input bit l0, input bit r0, input bit l1, input bit r1,
                              input bit t, input bit rdy, input int e0, input int e1,
                              input bit vld, input bit pl, input int upos, input bit bsy);
    vec_t v;
    v.l0 = l0; v.r0 = r0; v.l1 = l1; v.r1 = r1; v.t = t; v.rdy = rdy;
    v.e0 = e0; v.e1 = e1; v.vld = vld; v.pl = pl; v.upos = upos; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    {p0_left, p0_right, p1_left, p1_right, tick, upd_ready} = {v.l0, v.r0, v.l1, v.r1, v.t, v.rdy};
    if (v.e0 != prev0) sb.push_back('{1'b0, v.e0});
    if (v.e1 != prev1) sb.push_back('{1'b1, v.e1});
    prev0 = v.e0;
    prev1 = v.e1;
    @(posedge clk);
    #1;
    chk({nm, ".pos0"}, int'(pos0), v.e0);
    chk({nm, ".pos1"}, int'(pos1), v.e1);
    chk({nm, ".upd_valid"}, int'(upd_valid), int'(v.vld));
    chk({nm, ".busy"}, int'(busy), int'(v.bsy));
    if (v.vld) begin
      chk({nm, ".upd_player"}, int'(upd_player), int'(v.pl));
      chk({nm, ".upd_pos"}, int'(upd_pos), v.upos);
    end
  endtask

  // Every accepted update must match the oldest expected one.
  always @(negedge clk) begin
    upd_t e;
    if (rst_n && upd_valid && upd_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb.unexpected: player %0d pos %0d with nothing expected", upd_player, upd_pos);
      end else begin
        e = sb.pop_front();
        chk("sb.player", int'(upd_player), int'(e.pl));
        chk("sb.pos", int'(upd_pos), e.pos);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {p0_left, p0_right, p1_left, p1_right, tick, upd_ready} = '0;

    // Contention from reset: player 0 first, then player 1 back-to-back.
    tbl.push_back(mk(1,0,0,1,0,1, 20,20, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,1,1, 20,20, 0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 20,20, 1,0,19, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 19,20, 1,1,21, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 19,21, 0,0,0, 0));
    // Single player: three rights, three ticks, a fourth tick does nothing.
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0,1,0,0,0,1, 19,21, 0,0,0, 0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0,0,0,0,1,1, 19+k,21, 0,0,0, 1));
      tbl.push_back(mk(0,0,0,0,0,1, 19+k,21, 1,0,20+k, 1));
      tbl.push_back(mk(0,0,0,0,0,1, 20+k,21, 0,0,0, 0));
    end
    tbl.push_back(mk(0,0,0,0,1,1, 22,21, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,0,1, 22,21, 0,0,0, 0));
    // Second contention after a player-0 grant: player 1 first.
    tbl.push_back(mk(0,1,1,0,0,1, 22,21, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,1,1, 22,21, 0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 22,21, 1,1,20, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 22,20, 1,0,23, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 23,20, 0,0,0, 0));
    // Backpressure: offer held stable for five stalled cycles.
    tbl.push_back(mk(0,0,0,1,0,0, 23,20, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 23,20, 0,0,0, 1));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(0,0,0,0,0,0, 23,20, 1,1,21, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 23,21, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,0,1, 23,21, 0,0,0, 0));
    // Left+right together cancel; a pulse on the handshake edge adds to the consumed count.
    tbl.push_back(mk(1,1,0,0,0,1, 23,21, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,1,1, 23,21, 0,0,0, 0));
    tbl.push_back(mk(0,1,0,0,0,1, 23,21, 0,0,0, 0));
    tbl.push_back(mk(0,1,0,0,0,1, 23,21, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,1,1, 23,21, 0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0,1, 23,21, 1,0,24, 1));
    tbl.push_back(mk(0,1,0,0,0,1, 24,21, 0,0,0, 0));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(0,0,0,0,1,1, 24+k,21, 0,0,0, 1));
      tbl.push_back(mk(0,0,0,0,0,1, 24+k,21, 1,0,25+k, 1));
      tbl.push_back(mk(0,0,0,0,0,1, 25+k,21, 0,0,0, 0));
    end
    tbl.push_back(mk(0,0,0,0,1,1, 26,21, 0,0,0, 0));
    // Saturation: six rights give only three steps.
    for (int k = 0; k < 6; k++) tbl.push_back(mk(0,0,0,1,0,1, 26,21, 0,0,0, 0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0,0,0,0,1,1, 26,21+k, 0,0,0, 1));
      tbl.push_back(mk(0,0,0,0,0,1, 26,21+k, 1,1,22+k, 1));
      tbl.push_back(mk(0,0,0,0,0,1, 26,22+k, 0,0,0, 0));
    end
    tbl.push_back(mk(0,0,0,0,1,1, 26,24, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,0,1, 26,24, 0,0,0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.pos0", int'(pos0), 20);
    chk("reset.pos1", int'(pos1), 20);
    chk("reset.upd_valid", int'(upd_valid), 0);
    chk("reset.upd_player", int'(upd_player), 0);
    chk("reset.upd_pos", int'(upd_pos), 0);
    chk("reset.busy", int'(busy), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Walk player 0 down to the left limit.
    for (int k = 0; k < 26; k++) begin
      apply(mk(1,0,0,0,0,1, 26-k,24, 0,0,0, 0), "down.pulse");
      apply(mk(0,0,0,0,1,1, 26-k,24, 0,0,0, 1), "down.tick");
      apply(mk(0,0,0,0,0,1, 26-k,24, 1,0,25-k, 1), "down.offer");
      apply(mk(0,0,0,0,0,1, 25-k,24, 0,0,0, 0), "down.take");
    end
    // At 0 a left request is dropped and its pending count cleared.
    apply(mk(1,0,0,0,0,1, 0,24, 0,0,0, 0), "lim.pulse");
    apply(mk(0,0,0,0,1,1, 0,24, 0,0,0, 0), "lim.tick");
    apply(mk(0,0,0,0,0,1, 0,24, 0,0,0, 0), "lim.idle");
    apply(mk(0,1,0,0,0,1, 0,24, 0,0,0, 0), "lim.rpulse");
    apply(mk(0,0,0,0,1,1, 0,24, 0,0,0, 1), "lim.rtick");
    apply(mk(0,0,0,0,0,1, 0,24, 1,0,1, 1), "lim.offer");
    apply(mk(0,0,0,0,0,1, 1,24, 0,0,0, 0), "lim.take");

    // Reset while an offer is stalled.
    apply(mk(0,0,1,0,0,0, 1,24, 0,0,0, 0), "rst.pulse");
    apply(mk(0,0,0,0,1,0, 1,24, 0,0,0, 1), "rst.tick");
    apply(mk(0,0,0,0,0,0, 1,24, 1,1,23, 1), "rst.offer");
    rst_n = 1'b0;
    #1;
    chk("rst.pos0", int'(pos0), 20);
    chk("rst.pos1", int'(pos1), 20);
    chk("rst.upd_valid", int'(upd_valid), 0);
    chk("rst.upd_pos", int'(upd_pos), 0);
    chk("rst.busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev0 = 20;
    prev1 = 20;
    @(posedge clk);
    #1;
    apply(mk(0,0,0,0,1,1, 20,20, 0,0,0, 0), "post.tick");
    apply(mk(0,0,0,1,0,1, 20,20, 0,0,0, 0), "post.pulse");
    apply(mk(0,0,0,0,1,1, 20,20, 0,0,0, 1), "post.tick2");
    apply(mk(0,0,0,0,0,1, 20,20, 1,1,21, 1), "post.offer");
    apply(mk(0,0,0,0,0,1, 20,21, 0,0,0, 0), "post.take");

    chk("sb.leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
